// File: rtl/cmu_wbuf_if.sv
`default_nettype none
// ============================================================================
//  Module   : cmu_wbuf_if
//  Purpose  : Bundle of the cache-side and RAM-side signals of the posted
//             write buffer cmu_wbuf.
//  Signals  : c_*      cache request/response (cache is the requester)
//             m_*      RAM request/response (write buffer is the requester)
//             wb_empty flush-complete status
//             fwd_hit  read-served-from-buffer pulse
//  Modports : slave  - the write buffer's view
//             master - the environment's view (cache + RAM)
//  Revision : 1.0  initial release
// ============================================================================
interface cmu_wbuf_if;
   logic        c_cs;
   logic        c_we;
   logic [31:0] c_addr;
   logic [31:0] c_din;
   logic [31:0] c_dout;
   logic        c_ack;
   logic        m_cs;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_din;
   logic [31:0] m_dout;
   logic        m_ack;
   logic        wb_empty;
   logic        fwd_hit;

   modport slave (
      input  c_cs, c_we, c_addr, c_din, m_dout, m_ack,
      output c_dout, c_ack, m_cs, m_we, m_addr, m_din, wb_empty, fwd_hit
   );

   modport master (
      output c_cs, c_we, c_addr, c_din, m_dout, m_ack,
      input  c_dout, c_ack, m_cs, m_we, m_addr, m_din, wb_empty, fwd_hit
   );
endinterface
`default_nettype wire

// File: rtl/cmu_wbuf.sv
`default_nettype none
// ============================================================================
//  Module   : cmu_wbuf
//  Purpose  : Posted write buffer between the cache memory-side port and a
//             multi-cycle data RAM. Writes are acknowledged one cycle after
//             acceptance and drained to RAM oldest-first in the background.
//             Reads that hit a buffered write are served from the youngest
//             matching entry; reads that miss go to RAM ahead of drains.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous, active-low reset
//             bus  - cmu_wbuf_if.slave (c_* cache port, m_* RAM port,
//                    wb_empty, fwd_hit); all outputs are registered
//  Params   : DEPTH - buffer entries (power of two, >= 2)
//             PTR_W - log2(DEPTH)
//  Revision : 1.0  initial release
// ============================================================================
module cmu_wbuf #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  wire logic   clk,
   input  wire logic   rst,
   cmu_wbuf_if.slave   bus
);

   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2
   } state_t;

   // Control / output registers
   state_t             state_q,    state_d;
   logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
   logic [CNT_W-1:0]   count_q,    count_d;
   logic               rd_pend_q,  rd_pend_d;
   logic               c_ack_q,    c_ack_d;
   logic [31:0]        c_dout_q,   c_dout_d;
   logic               fwd_hit_q,  fwd_hit_d;
   logic               m_cs_q,     m_cs_d;
   logic               m_we_q,     m_we_d;
   logic [31:0]        m_addr_q,   m_addr_d;
   logic [31:0]        m_din_q,    m_din_d;
   logic               wb_empty_q, wb_empty_d;

   // Buffer storage (word address + data); contents need no reset because
   // validity is tracked solely by rd_ptr/count.
   logic [29:0]        ent_addr_q [DEPTH];
   logic [29:0]        ent_addr_d [DEPTH];
   logic [31:0]        ent_data_q [DEPTH];
   logic [31:0]        ent_data_d [DEPTH];

   logic               w_accept;
   logic               w_enq;
   logic               w_deq;
   logic               w_hit;
   logic [31:0]        w_hit_data;
   logic [PTR_W-1:0]   w_idx;

   // A request is looked at only while no ack is being presented (so the ack
   // cycle never re-accepts) and no earlier read miss is still outstanding.
   assign w_accept = bus.c_cs && !c_ack_q && !rd_pend_q;
   assign w_enq    = w_accept && bus.c_we && (count_q < C_DEPTH);
   assign w_deq    = (state_q == ST_WR) && bus.m_ack;

   // Forwarding search: walk valid entries oldest to youngest so the last
   // match (the youngest) wins. The head is still valid while it drains.
   always_comb begin
      w_hit      = 1'b0;
      w_hit_data = '0;
      w_idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = rd_ptr_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && (ent_addr_q[w_idx] == bus.c_addr[31:2])) begin
            w_hit      = 1'b1;
            w_hit_data = ent_data_q[w_idx];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rd_pend_d  = rd_pend_q;
      c_ack_d    = 1'b0;
      fwd_hit_d  = 1'b0;
      c_dout_d   = c_dout_q;
      m_cs_d     = m_cs_q;
      m_we_d     = m_we_q;
      m_addr_d   = m_addr_q;
      m_din_d    = m_din_q;
      ent_addr_d = ent_addr_q;
      ent_data_d = ent_data_q;

      // Pointers wrap naturally because DEPTH is a power of two.
      wr_ptr_d = wr_ptr_q + PTR_W'(w_enq);
      rd_ptr_d = rd_ptr_q + PTR_W'(w_deq);
      count_d  = count_q + CNT_W'(w_enq) - CNT_W'(w_deq);

      if (w_enq) begin
         ent_addr_d[wr_ptr_q] = bus.c_addr[31:2];
         ent_data_d[wr_ptr_q] = bus.c_din;
         c_ack_d              = 1'b1;
      end

      if (w_accept && !bus.c_we) begin
         if (w_hit) begin
            c_dout_d  = w_hit_data;
            c_ack_d   = 1'b1;
            fwd_hit_d = 1'b1;
         end else begin
            rd_pend_d = 1'b1;
         end
      end

      // RAM sequencer: a pending read outranks draining. A drain in flight
      // always completes before the read is issued.
      case (state_q)
         ST_IDLE: begin
            if (rd_pend_q) begin
               state_d  = ST_RD;
               m_cs_d   = 1'b1;
               m_we_d   = 1'b0;
               m_addr_d = bus.c_addr;
            end else if (count_q != '0) begin
               state_d  = ST_WR;
               m_cs_d   = 1'b1;
               m_we_d   = 1'b1;
               m_addr_d = {ent_addr_q[rd_ptr_q], 2'b00};
               m_din_d  = ent_data_q[rd_ptr_q];
            end
         end
         ST_WR: begin
            if (bus.m_ack) begin
               state_d = ST_IDLE;
               m_cs_d  = 1'b0;
               m_we_d  = 1'b0;
            end
         end
         ST_RD: begin
            if (bus.m_ack) begin
               state_d   = ST_IDLE;
               m_cs_d    = 1'b0;
               c_dout_d  = bus.m_dout;
               c_ack_d   = 1'b1;
               rd_pend_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            m_cs_d  = 1'b0;
            m_we_d  = 1'b0;
         end
      endcase

      wb_empty_d = (count_d == '0) && (state_d == ST_IDLE) && !rd_pend_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_pend_q  <= 1'b0;
         c_ack_q    <= 1'b0;
         c_dout_q   <= '0;
         fwd_hit_q  <= 1'b0;
         m_cs_q     <= 1'b0;
         m_we_q     <= 1'b0;
         m_addr_q   <= '0;
         m_din_q    <= '0;
         wb_empty_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_pend_q  <= rd_pend_d;
         c_ack_q    <= c_ack_d;
         c_dout_q   <= c_dout_d;
         fwd_hit_q  <= fwd_hit_d;
         m_cs_q     <= m_cs_d;
         m_we_q     <= m_we_d;
         m_addr_q   <= m_addr_d;
         m_din_q    <= m_din_d;
         wb_empty_q <= wb_empty_d;
      end
   end

   always_ff @(posedge clk) begin
      ent_addr_q <= ent_addr_d;
      ent_data_q <= ent_data_d;
   end

   assign bus.c_ack    = c_ack_q;
   assign bus.c_dout   = c_dout_q;
   assign bus.fwd_hit  = fwd_hit_q;
   assign bus.m_cs     = m_cs_q;
   assign bus.m_we     = m_we_q;
   assign bus.m_addr   = m_addr_q;
   assign bus.m_din    = m_din_q;
   assign bus.wb_empty = wb_empty_q;

endmodule
`default_nettype wire

// File: tb/tb_cmu_wbuf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmu_wbuf
//  Purpose  : Self-checking bench for cmu_wbuf: directed cache traffic, a RAM
//             responder with programmable latency, a queue-based reference
//             model compared every cycle, and hand-computed expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cmu_wbuf;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_err = 0;

   cmu_wbuf_if bus ();

   cmu_wbuf #(.DEPTH(DEPTH), .PTR_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- RAM responder ----------------
   logic [31:0] mem [logic [31:0]];
   logic [32:0] oplog [$];
   int          mack_q [$];
   int          ram_delay = 3;
   int          ram_cnt = 0;

   initial begin
      bus.m_ack  = 1'b0;
      bus.m_dout = '0;
      forever begin
         @(negedge clk);
         if (!rst || bus.m_ack) begin
            bus.m_ack = 1'b0;
            ram_cnt   = 0;
         end else if (bus.m_cs) begin
            ram_cnt++;
            if (ram_cnt >= ram_delay) begin
               if (bus.m_we) mem[bus.m_addr] = bus.m_din;
               else bus.m_dout = mem.exists(bus.m_addr) ? mem[bus.m_addr] : 32'h0;
               oplog.push_back({bus.m_we, bus.m_addr});
               mack_q.push_back(cyc + 1);
               bus.m_ack = 1'b1;
            end
         end else begin
            ram_cnt = 0;
         end
      end
   end

   // ---------------- Reference model ----------------
   typedef struct packed {
      logic [29:0] a;
      logic [31:0] d;
   } ent_t;

   ent_t        mq [$];
   bit          md_pend;
   int          md_op;        // 0 none, 1 drain write, 2 read
   bit          e_ack, e_fwd;
   logic [31:0] e_dout, e_maddr, e_mdin;

   always @(posedge clk or negedge rst) begin
      bit p_ack, p_pend, push, found, n_ack, n_fwd;
      int p_op, sz;
      if (!rst) begin
         mq.delete();
         md_pend = 0; md_op = 0; e_ack = 0; e_fwd = 0;
         e_dout = '0; e_maddr = '0; e_mdin = '0;
      end else begin
         p_ack = e_ack; p_pend = md_pend; p_op = md_op; sz = mq.size();
         push = 0; n_ack = 0; n_fwd = 0; found = 0;
         if (bus.c_cs && !p_ack && !p_pend) begin
            if (bus.c_we) begin
               if (sz < DEPTH) begin push = 1; n_ack = 1; end
            end else begin
               for (int i = 0; i < sz; i++)
                  if (mq[i].a == bus.c_addr[31:2]) begin found = 1; e_dout = mq[i].d; end
               if (found) begin n_ack = 1; n_fwd = 1; end
               else md_pend = 1;
            end
         end
         case (p_op)
            0: if (p_pend) begin
                  md_op = 2; e_maddr = bus.c_addr;
               end else if (sz > 0) begin
                  md_op = 1; e_maddr = {mq[0].a, 2'b00}; e_mdin = mq[0].d;
               end
            1: if (bus.m_ack) begin void'(mq.pop_front()); md_op = 0; end
            default: if (bus.m_ack) begin
                  e_dout = bus.m_dout; n_ack = 1; md_pend = 0; md_op = 0;
               end
         endcase
         if (push) mq.push_back({bus.c_addr[31:2], bus.c_din});
         e_ack = n_ack;
         e_fwd = n_fwd;
      end
   end

   // ---------------- Per-cycle compare ----------------
   always @(posedge clk) begin
      #2;
      chk("c_ack", bus.c_ack, e_ack);
      chk("fwd_hit", bus.fwd_hit, e_fwd);
      chk("m_cs", bus.m_cs, md_op != 0);
      chk("wb_empty", bus.wb_empty, (mq.size() == 0) && (md_op == 0) && !md_pend);
      if (e_ack) chk("c_dout", bus.c_dout, e_dout);
      if (md_op != 0) begin
         chk("m_we", bus.m_we, md_op == 1);
         chk("m_addr", bus.m_addr, e_maddr);
         if (md_op == 1) chk("m_din", bus.m_din, e_mdin);
      end
   end

   // ---------------- Stimulus helpers ----------------
   task automatic req(input bit we, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] dout, output bit fwd, output int acyc);
      int  start;
      bit  done;
      bus.c_cs = 1'b1; bus.c_we = we; bus.c_addr = a; bus.c_din = d;
      start = cyc; done = 0; lat = -1; dout = '0; fwd = 0; acyc = -1;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge clk);
         if (bus.c_ack) begin
            done = 1; lat = cyc - start; dout = bus.c_dout; fwd = bus.fwd_hit; acyc = cyc;
         end
      end
      if (!done) begin
         n_checks++; n_err++;
         $display("FAIL req_timeout: addr %h got no c_ack, required c_ack within 300 cycles", a);
      end
      bus.c_cs = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      bit ok;
      ok = 0;
      for (int k = 0; k < 500 && !ok; k++) begin
         @(negedge clk);
         if (bus.wb_empty) ok = 1;
      end
      chk(name, ok, 1'b1);
   endtask

   function automatic logic [31:0] rdmem(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'hDEAD_DEAD;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish before 1000000");
      $fatal(1, "watchdog");
   end

   // ---------------- Directed tests ----------------
   initial begin
      int          lat, acyc, bcnt;
      logic [31:0] dout;
      bit          fwd;
      int          lats [5];
      int          acycs [5];

      bus.c_cs = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_din = '0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_wb_empty", bus.wb_empty, 1'b1);
      chk("reset_c_ack", bus.c_ack, 1'b0);
      chk("reset_m_cs", bus.m_cs, 1'b0);
      rst = 1'b1;
      @(negedge clk);

      // Single write with RAM latency 3
      ram_delay = 3;
      req(1, 32'h04, 32'h11, lat, dout, fwd, acyc);
      chk("write1_latency", lat, 1);
      wait_empty("write1_drain");
      chk("write1_ram", rdmem(32'h04), 32'h11);

      // Fill: slow RAM so the fifth write must wait for a freed slot
      ram_delay = 12;
      mack_q.delete();
      for (int i = 0; i < 5; i++) begin
         req(1, 32'(i * 4), 32'h100 + 32'(i), lats[i], dout, fwd, acycs[i]);
      end
      chk("fill_lat0", lats[0], 1);
      chk("fill_lat1", lats[1], 2);
      chk("fill_lat3", lats[3], 2);
      chk("fill_5th_after_mack", acycs[4], (mack_q.size() > 0) ? mack_q[0] + 1 : -1);
      wait_empty("fill_drain");
      for (int i = 0; i < 5; i++) chk("fill_ram", rdmem(32'(i * 4)), 32'h100 + 32'(i));

      // Forward from youngest matching entry
      req(1, 32'h08, 32'hAA, lat, dout, fwd, acyc);
      req(1, 32'h08, 32'hBB, lat, dout, fwd, acyc);
      @(negedge clk);
      req(0, 32'h08, 32'h0, lat, dout, fwd, acyc);
      chk("fwd_data", dout, 32'hBB);
      chk("fwd_flag", fwd, 1'b1);
      chk("fwd_latency", lat, 1);
      wait_empty("fwd_drain");
      chk("fwd_ram", rdmem(32'h08), 32'hBB);

      // Read miss bypasses the second queued drain
      ram_delay = 3;
      mem[32'h20] = 32'hCAFE_0020;
      oplog.delete();
      req(1, 32'h30, 32'h1, lat, dout, fwd, acyc);
      req(1, 32'h34, 32'h2, lat, dout, fwd, acyc);
      req(0, 32'h20, 32'h0, lat, dout, fwd, acyc);
      chk("bypass_data", dout, 32'hCAFE_0020);
      chk("bypass_fwd", fwd, 1'b0);
      wait_empty("bypass_drain");
      chk("bypass_nops", oplog.size(), 3);
      if (oplog.size() == 3) begin
         chk("bypass_op0", oplog[0], {1'b1, 32'h30});
         chk("bypass_op1", oplog[1], {1'b0, 32'h20});
         chk("bypass_op2", oplog[2], {1'b1, 32'h34});
      end

      // Wrap: ten back-to-back writes interleaved with drains
      oplog.delete();
      for (int i = 0; i < 10; i++)
         req(1, 32'h100 + 32'(i * 4), 32'h1000 + 32'(i), lat, dout, fwd, acyc);
      wait_empty("wrap_drain");
      chk("wrap_nops", oplog.size(), 10);
      for (int i = 0; i < 10; i++) begin
         chk("wrap_ram", rdmem(32'h100 + 32'(i * 4)), 32'h1000 + 32'(i));
         if (i < oplog.size()) chk("wrap_order", oplog[i], {1'b1, 32'h100 + 32'(i * 4)});
      end

      // Reset in the middle of a drain
      ram_delay = 6;
      req(1, 32'h200, 32'h55, lat, dout, fwd, acyc);
      bcnt = 0;
      while (!bus.m_cs && bcnt < 20) begin @(negedge clk); bcnt++; end
      chk("rst_mid_wr_started", bus.m_cs, 1'b1);
      rst = 1'b0;
      #1;
      chk("rst_mid_m_cs", bus.m_cs, 1'b0);
      chk("rst_mid_wb_empty", bus.wb_empty, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      req(1, 32'h204, 32'h77, lat, dout, fwd, acyc);
      chk("post_rst_latency", lat, 1);
      wait_empty("post_rst_drain");
      chk("post_rst_ram", rdmem(32'h204), 32'h77);
      chk("discarded_write", mem.exists(32'h200), 1'b0);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
